// File: rtl/elevator_ctrl_pkg.sv
// Shared types for the elevator car controller: FSM state encoding,
// scan-direction constants and a counter-width helper.
package elevator_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_ARRIVE    = 3'd3,
    ST_DOOR      = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width able to hold max(a,b)-1, never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_ctrl_req_scan.sv
// Combinational request scan: collapses the three call vectors into
// "anything above / below / at" the current floor.
module req_scan #(
  parameter  int N  = 8,
  localparam int FW = $clog2(N)
) (
  input  logic [FW-1:0] cur_floor_i,
  input  logic [N-1:0]  cabin_i,
  input  logic [N-1:0]  up_i,
  input  logic [N-1:0]  down_i,
  output logic          req_above_o,
  output logic          req_below_o,
  output logic          any_here_o
);

  logic [N-1:0] any_v;
  logic [N-1:0] here_oh;
  logic [N-1:0] below_m;
  logic [N-1:0] above_m;

  assign any_v   = cabin_i | up_i | down_i;
  assign here_oh = N'(1) << cur_floor_i;
  // Thermometer masks derived from the one-hot floor position.
  assign below_m = here_oh - N'(1);
  assign above_m = ~(below_m | here_oh);

  assign req_above_o = |(any_v & above_m);
  assign req_below_o = |(any_v & below_m);
  assign any_here_o  = |(any_v & here_oh);

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller: picks direction, times travel and door dwell,
// and strobes inactivate lines for calls served at the current floor.
module elevator_ctrl
  import elevator_ctrl_pkg::*;
#(
  parameter  int BUTTONS_WIDTH = 8,
  parameter  int TRAVEL_CYCLES = 100,
  parameter  int DOOR_CYCLES   = 50,
  localparam int N  = BUTTONS_WIDTH,
  localparam int FW = $clog2(BUTTONS_WIDTH),
  localparam int CW = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  active_in_levels,
  input  logic [N-2:0]  active_out_up_levels,
  input  logic [N-1:1]  active_out_down_levels,
  output logic [N-1:0]  inactivate_in_levels,
  output logic [N-2:0]  inactivate_out_up_levels,
  output logic [N-1:1]  inactivate_out_down_levels,
  output logic [FW-1:0] cur_floor,
  output logic          motor_up,
  output logic          motor_down,
  output logic          door_open,
  output logic          dir_up
);

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] floor_q, floor_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mup_q, mdn_q, door_q;
  logic [N-1:0]  clr_in_q, clr_in_d;
  logic [N-2:0]  clr_up_q, clr_up_d;
  logic [N-1:1]  clr_dn_q, clr_dn_d;

  logic [N-1:0]  up_full, dn_full, here_oh;
  logic          req_above, req_below, any_here;
  logic          ahead, behind, hall_fwd, hall_rev, cabin_here;
  logic          stop_here, turn, idle_after;

  assign up_full = {1'b0, active_out_up_levels};
  assign dn_full = {active_out_down_levels, 1'b0};
  assign here_oh = N'(1) << floor_q;

  req_scan #(.N(N)) u_scan (
    .cur_floor_i (floor_q),
    .cabin_i     (active_in_levels),
    .up_i        (up_full),
    .down_i      (dn_full),
    .req_above_o (req_above),
    .req_below_o (req_below),
    .any_here_o  (any_here)
  );

  assign ahead      = dir_q ? req_above : req_below;
  assign behind     = dir_q ? req_below : req_above;
  assign hall_fwd   = (dir_q == DIR_DOWN) ? dn_full[floor_q] : up_full[floor_q];
  assign hall_rev   = (dir_q == DIR_DOWN) ? up_full[floor_q] : dn_full[floor_q];
  assign cabin_here = active_in_levels[floor_q];
  assign stop_here  = cabin_here | hall_fwd | ~ahead;
  // A hall call pointing back at this floor also counts as work on the other side.
  assign turn       = ~ahead & (behind | hall_rev);
  assign idle_after = ~req_above & ~req_below;

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (any_here) begin
          state_d = ST_DOOR;
          dir_d   = dir_q ^ turn;
        end else if (ahead) begin
          state_d = dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (behind) begin
          dir_d   = ~dir_q;
          state_d = dir_q ? ST_MOVE_DOWN : ST_MOVE_UP;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (cnt_q == TRAVEL_LAST) begin
          cnt_d   = '0;
          state_d = ST_ARRIVE;
          floor_d = (state_q == ST_MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ARRIVE: begin
        cnt_d = '0;
        if (stop_here) begin
          state_d = ST_DOOR;
          dir_d   = dir_q ^ turn;
        end else begin
          state_d = dir_q ? ST_MOVE_UP : ST_MOVE_DOWN;
        end
      end
      ST_DOOR: begin
        if (cnt_q == DOOR_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clears track the direction the car will leave in; both hall bits go when it will idle.
  always_comb begin
    clr_in_d = '0;
    clr_up_d = '0;
    clr_dn_d = '0;
    if (state_d == ST_DOOR) begin
      clr_in_d = here_oh;
      if (dir_d | idle_after)  clr_up_d = here_oh[N-2:0];
      if (~dir_d | idle_after) clr_dn_d = here_oh[N-1:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      floor_q  <= '0;
      dir_q    <= DIR_UP;
      cnt_q    <= '0;
      mup_q    <= 1'b0;
      mdn_q    <= 1'b0;
      door_q   <= 1'b0;
      clr_in_q <= '0;
      clr_up_q <= '0;
      clr_dn_q <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      mup_q    <= (state_d == ST_MOVE_UP);
      mdn_q    <= (state_d == ST_MOVE_DOWN);
      door_q   <= (state_d == ST_DOOR);
      clr_in_q <= clr_in_d;
      clr_up_q <= clr_up_d;
      clr_dn_q <= clr_dn_d;
    end
  end

  assign cur_floor                  = floor_q;
  assign dir_up                     = dir_q;
  assign motor_up                   = mup_q;
  assign motor_down                 = mdn_q;
  assign door_open                  = door_q;
  assign inactivate_in_levels       = clr_in_q;
  assign inactivate_out_up_levels   = clr_up_q;
  assign inactivate_out_down_levels = clr_dn_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: button block loopback, procedural timed reference
// model of the car, directed scenarios followed by random calls and resets.
module tb_elevator_ctrl;
  localparam int N = 8;
  localparam int T = 4;
  localparam int D = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] b_in = '0, b_up = '0, b_dn = '0;
  logic [N-1:0] p_in = '0, p_up = '0, p_dn = '0;
  logic [N-1:0] inact_in;
  logic [N-2:0] inact_up;
  logic [N-1:1] inact_dn;
  logic [2:0]   cur_floor;
  logic         motor_up, motor_down, door_open, dir_up;

  int n_chk = 0;
  int n_err = 0;

  int   m_floor = 0;
  bit   m_dir = 1'b1;
  bit   m_rst = 1'b0;
  logic e_mup = 1'b0, e_mdn = 1'b0, e_door = 1'b0;
  logic [N-1:0] e_cin = '0, e_cup = '0, e_cdn = '0;

  elevator_ctrl #(.BUTTONS_WIDTH(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .active_in_levels           (b_in),
    .active_out_up_levels       (b_up[N-2:0]),
    .active_out_down_levels     (b_dn[N-1:1]),
    .inactivate_in_levels       (inact_in),
    .inactivate_out_up_levels   (inact_up),
    .inactivate_out_down_levels (inact_dn),
    .cur_floor                  (cur_floor),
    .motor_up                   (motor_up),
    .motor_down                 (motor_down),
    .door_open                  (door_open),
    .dir_up                     (dir_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit any_at(int f);
    return b_in[f] | b_up[f] | b_dn[f];
  endfunction

  function automatic bit req_span(int lo, int hi);
    bit r = 1'b0;
    for (int f = lo; f <= hi; f++) r |= any_at(f);
    return r;
  endfunction

  function automatic bit above();
    return req_span(m_floor + 1, N - 1);
  endfunction

  function automatic bit below();
    return req_span(0, m_floor - 1);
  endfunction

  task automatic set_out(input bit u, input bit d, input bit o);
    e_mup = u; e_mdn = d; e_door = o;
    e_cin = '0; e_cup = '0; e_cdn = '0;
  endtask

  task automatic m_edge();
    @(posedge clk);
    m_rst = reset;
    if (reset) begin
      m_floor = 0;
      m_dir   = 1'b1;
      set_out(0, 0, 0);
    end
  endtask

  task automatic door_clears();
    bit idle;
    idle  = !above() && !below();
    e_cin = '0; e_cup = '0; e_cdn = '0;
    e_cin[m_floor] = 1'b1;
    if (m_floor < N - 1 && (m_dir || idle))  e_cup[m_floor] = 1'b1;
    if (m_floor > 0     && (!m_dir || idle)) e_cdn[m_floor] = 1'b1;
  endtask

  task automatic m_door();
    bit ahead, behind, opp;
    ahead  = m_dir ? above() : below();
    behind = m_dir ? below() : above();
    opp    = m_dir ? b_dn[m_floor] : b_up[m_floor];
    if (!ahead && (behind || opp)) m_dir = !m_dir;
    for (int k = 0; k < D; k++) begin
      if (k > 0) begin
        m_edge();
        if (m_rst) return;
      end
      set_out(0, 0, 1);
      door_clears();
    end
    m_edge();
    if (m_rst) return;
    set_out(0, 0, 0);
  endtask

  task automatic m_travel();
    bit ahead, fwd;
    forever begin
      set_out(m_dir, !m_dir, 0);
      repeat (T - 1) begin
        m_edge();
        if (m_rst) return;
      end
      m_edge();
      if (m_rst) return;
      m_floor += m_dir ? 1 : -1;
      set_out(0, 0, 0);
      m_edge();
      if (m_rst) return;
      ahead = m_dir ? above() : below();
      fwd   = m_dir ? b_up[m_floor] : b_dn[m_floor];
      if (b_in[m_floor] || fwd || !ahead) begin
        m_door();
        return;
      end
    end
  endtask

  initial begin : model
    forever begin
      m_edge();
      if (!m_rst) begin
        if (any_at(m_floor)) m_door();
        else if (m_dir ? above() : below()) m_travel();
        else if (m_dir ? below() : above()) begin
          m_dir = !m_dir;
          m_travel();
        end else set_out(0, 0, 0);
      end
    end
  end

  // ---------------- stimulus / checking ----------------
  task automatic cyc();
    @(negedge clk);
    chk("cur_floor", 32'(cur_floor), 32'(m_floor));
    chk("dir_up", 32'(dir_up), 32'(m_dir));
    chk("motor_up", 32'(motor_up), 32'(e_mup));
    chk("motor_down", 32'(motor_down), 32'(e_mdn));
    chk("door_open", 32'(door_open), 32'(e_door));
    chk("clr_in", 32'(inact_in), 32'(e_cin));
    chk("clr_up", 32'(inact_up), 32'(e_cup[N-2:0]));
    chk("clr_dn", 32'(inact_dn), 32'(e_cdn[N-1:1]));
    b_in = (b_in | p_in) & ~inact_in;
    b_up = (b_up | p_up) & ~{1'b0, inact_up};
    b_dn = (b_dn | p_dn) & ~{inact_dn, 1'b0};
    b_up[N-1] = 1'b0;
    b_dn[0]   = 1'b0;
    if (reset) begin
      b_in = '0; b_up = '0; b_dn = '0;
    end
    p_in = '0; p_up = '0; p_dn = '0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_floor(input int f, input bit need_down, input string tag);
    int budget = 200;
    while (budget > 0 && !(cur_floor == 3'(f) && (!need_down || motor_down))) begin
      cyc();
      budget--;
    end
    chk(tag, 32'(budget > 0), 32'd1);
  endtask

  initial begin : stim
    int mcnt, dcnt, icnt, f;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // cabin call at the floor the car idles on: door next cycle, no motor
    p_in[0] = 1'b1;
    cyc();
    cyc();
    chk("s4_door_next", 32'(door_open), 32'd1);
    chk("s4_no_motor", 32'(motor_up | motor_down), 32'd0);
    run(10);

    // single cabin call three floors up
    p_in[3] = 1'b1;
    mcnt = 0; dcnt = 0; icnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      mcnt += int'(motor_up);
      dcnt += int'(door_open);
      if (door_open && inact_in == 8'h08) icnt++;
    end
    chk("s1_motor_cycles", 32'(mcnt), 32'(3 * T));
    chk("s1_door_cycles", 32'(dcnt), 32'(D));
    chk("s1_clr_cycles", 32'(icnt), 32'(D));
    chk("s1_floor", 32'(cur_floor), 32'd3);

    // hall down at the top floor
    p_dn[7] = 1'b1;
    run(40);
    chk("top_floor", 32'(cur_floor), 32'd7);
    chk("top_dir", 32'(dir_up), 32'd0);

    // reset while moving down through floor 4
    p_in[0] = 1'b1;
    wait_floor(4, 1'b1, "reach_f4_down");
    reset = 1'b1;
    cyc();
    chk("rst_floor", 32'(cur_floor), 32'd0);
    chk("rst_dir", 32'(dir_up), 32'd1);
    chk("rst_motor", 32'(motor_down), 32'd0);
    reset = 1'b0;
    run(2);

    // hall up at 2 and hall down at 5 from floor 0
    p_up[2] = 1'b1;
    p_dn[5] = 1'b1;
    run(50);
    chk("s2_floor", 32'(cur_floor), 32'd5);
    chk("s2_dir", 32'(dir_up), 32'd0);

    // cabin call behind the car is served on the way back
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    p_in[6] = 1'b1;
    wait_floor(2, 1'b0, "s3_reach2");
    p_in[1] = 1'b1;
    run(100);
    chk("s3_floor", 32'(cur_floor), 32'd1);
    chk("s3_dir", 32'(dir_up), 32'd0);

    // repeated presses at the current floor while the door is open
    f = m_floor;
    p_in[f] = 1'b1;
    cyc();
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      p_in[f] = 1'b1;
      cyc();
      dcnt += int'(door_open);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      dcnt += int'(door_open);
    end
    chk("s5_door_cycles", 32'(dcnt), 32'(D));

    // random calls with occasional reset
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        f = $urandom_range(0, N - 1);
        case ($urandom_range(0, 2))
          0: p_in[f] = 1'b1;
          1: if (f < N - 1) p_up[f] = 1'b1;
          default: if (f > 0) p_dn[f] = 1'b1;
        endcase
      end
      reset = ($urandom_range(0, 999) == 0);
      cyc();
    end
    reset = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
